// File: rtl/mem_io_responder_pkg.sv
// Shared constants for the memory/IO responder: IO register offsets,
// status bit positions and the read-data source select.
package mem_io_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

    localparam logic [31:0] IO_DATA_OFS = 32'd0;
    localparam logic [31:0] IO_STAT_OFS = 32'd4;
    localparam logic [31:0] IO_DROP_OFS = 32'd8;

    localparam int STAT_RX_NONEMPTY = 0;
    localparam int STAT_TX_FULL     = 1;

    typedef enum logic [1:0] {
        RD_ZERO,
        RD_RAM,
        RD_IO
    } rd_sel_e;

endpackage

// File: rtl/mem_io_responder_if.sv
// Byte-wide CPU memory bus plus the TX/RX byte streams toward the UART side.
// master = controller/board side, slave = responder.
interface mem_io_responder_if;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data_out;
    logic        tx_valid_out;
    logic        tx_ready_in;
    logic [7:0]  rx_data_in;
    logic        rx_valid_in;
    logic        rx_ready_out;

    modport master (
        output mem_a, mem_dout, mem_wr, tx_ready_in, rx_data_in, rx_valid_in,
        input  mem_din, io_buffer_full, tx_data_out, tx_valid_out, rx_ready_out
    );

    modport slave (
        input  mem_a, mem_dout, mem_wr, tx_ready_in, rx_data_in, rx_valid_in,
        output mem_din, io_buffer_full, tx_data_out, tx_valid_out, rx_ready_out
    );
endinterface

// File: rtl/mem_io_byte_fifo.sv
// Byte FIFO with 2**DEPTH_LOG entries; head and flags reflect current state.
// Push/pop take effect at the clock edge; same-cycle push+pop keeps count.
// Push into a full FIFO is refused unless a pop happens in the same cycle.
module mem_io_byte_fifo #(
    parameter int DEPTH_LOG = 3
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               push,
    input  logic [7:0]         push_dat,
    input  logic               pop,
    output logic [7:0]         head_dat,
    output logic               full,
    output logic               empty,
    output logic [DEPTH_LOG:0] count
);
    localparam int DEPTH = 1 << DEPTH_LOG;

    logic [7:0]           mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr;
    logic [DEPTH_LOG-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (DEPTH_LOG+1)'(DEPTH));
    assign head_dat = mem[rd_ptr];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (DEPTH_LOG+1)'(do_push) - (DEPTH_LOG+1)'(do_pop);
        end
    end

    // Storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge clk_in) begin
        if (do_push && !rst_in) mem[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/mem_io_responder.sv
// Responder for the byte memory bus: RAM, IO window, TX/RX byte FIFOs. Optional MEM_IO_DROP_CNT_EN adds a TX drop counter.
// Read data (mem_din) is registered: valid one cycle after the address.
// io_buffer_full warns at depth-1; IO writes into a full TX FIFO are dropped.
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 17,
    parameter logic [31:0] IO_BASE      = IO_BASE_DEFAULT,
    parameter int          TX_DEPTH_LOG = 3,
    parameter int          RX_DEPTH_LOG = 3
) (
    input  logic clk_in,
    input  logic rst_in,
    mem_io_responder_if.slave bus
);
    localparam logic [TX_DEPTH_LOG:0] TX_NEAR_FULL =
        (TX_DEPTH_LOG+1)'((1 << TX_DEPTH_LOG) - 1);

    logic [7:0]            ram [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic [7:0]            ram_q;
    logic [7:0]            io_q;
    logic [7:0]            io_rd_dat;
    rd_sel_e               rd_sel;
    logic                  is_io;
    logic [31:0]           io_ofs;
    logic                  io_data_rd;
    logic                  data_rd_q;
    logic                  tx_wr;
    logic                  tx_acc;
    logic                  tx_pop;
    logic                  tx_full;
    logic                  tx_empty;
    logic [TX_DEPTH_LOG:0] tx_count;
    logic [TX_DEPTH_LOG:0] tx_cnt_nxt;
    logic                  buf_full_q;
    logic                  rx_push;
    logic                  rx_pop;
    logic                  rx_full;
    logic                  rx_empty;
    logic [7:0]            rx_head;
    logic [RX_DEPTH_LOG:0] rx_count;

    assign is_io      = (bus.mem_a >= IO_BASE);
    assign io_ofs     = bus.mem_a - IO_BASE;
    assign ram_idx    = bus.mem_a[ADDR_WIDTH-1:0];
    assign io_data_rd = is_io && !bus.mem_wr && (io_ofs == IO_DATA_OFS);
    assign tx_wr      = is_io &&  bus.mem_wr && (io_ofs == IO_DATA_OFS);

    assign tx_pop     = bus.tx_valid_out && bus.tx_ready_in;
    assign tx_acc     = tx_wr && (!tx_full || tx_pop);
    assign tx_cnt_nxt = tx_count + (TX_DEPTH_LOG+1)'(tx_acc) - (TX_DEPTH_LOG+1)'(tx_pop);

    // A parked read of the data register pops only on its first cycle.
    assign rx_pop  = io_data_rd && !data_rd_q && !rx_empty;
    assign rx_push = bus.rx_valid_in && bus.rx_ready_out;

    assign bus.tx_valid_out   = !tx_empty;
    assign bus.rx_ready_out   = !rx_full && !rst_in;
    assign bus.io_buffer_full = buf_full_q;

    mem_io_byte_fifo #(.DEPTH_LOG(TX_DEPTH_LOG)) u_tx_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .push     (tx_wr),
        .push_dat (bus.mem_dout),
        .pop      (tx_pop),
        .head_dat (bus.tx_data_out),
        .full     (tx_full),
        .empty    (tx_empty),
        .count    (tx_count)
    );

    mem_io_byte_fifo #(.DEPTH_LOG(RX_DEPTH_LOG)) u_rx_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .push     (rx_push),
        .push_dat (bus.rx_data_in),
        .pop      (rx_pop),
        .head_dat (rx_head),
        .full     (rx_full),
        .empty    (rx_empty),
        .count    (rx_count)
    );

`ifdef MEM_IO_DROP_CNT_EN
    logic [15:0] drop_cnt;
    logic        tx_drop;

    assign tx_drop = tx_wr && !tx_acc;

    always_ff @(posedge clk_in) begin
        if (rst_in)                         drop_cnt <= '0;
        else if (tx_drop && drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
    end
`endif

    always_comb begin
        io_rd_dat = '0;
        if (io_ofs == IO_DATA_OFS) begin
            io_rd_dat = rx_empty ? 8'h00 : rx_head;
        end else if (io_ofs == IO_STAT_OFS) begin
            io_rd_dat[STAT_RX_NONEMPTY] = (rx_count != '0);
            io_rd_dat[STAT_TX_FULL]     = tx_full;
`ifdef MEM_IO_DROP_CNT_EN
        end else if (io_ofs == IO_DROP_OFS) begin
            io_rd_dat = drop_cnt[7:0];
        end else if (io_ofs == IO_DROP_OFS + 32'd1) begin
            io_rd_dat = drop_cnt[15:8];
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        if (!is_io && bus.mem_wr) ram[ram_idx] <= bus.mem_dout;
        ram_q <= ram[ram_idx];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_sel     <= RD_ZERO;
            io_q       <= '0;
            data_rd_q  <= 1'b0;
            buf_full_q <= 1'b0;
        end else begin
            if (bus.mem_wr)  rd_sel <= RD_ZERO;
            else if (is_io)  rd_sel <= RD_IO;
            else             rd_sel <= RD_RAM;
            io_q       <= io_rd_dat;
            data_rd_q  <= io_data_rd;
            buf_full_q <= (tx_cnt_nxt >= TX_NEAR_FULL);
        end
    end

    always_comb begin
        case (rd_sel)
            RD_RAM:  bus.mem_din = ram_q;
            RD_IO:   bus.mem_din = io_q;
            default: bus.mem_din = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: read data checked through a
// one-cycle scoreboard, TX/RX streams checked against queue models.
module tb_mem_io_responder;
    logic clk_in;
    logic rst_in;
    int   errors = 0;
    int   checks = 0;

    mem_io_responder_if mif();

    mem_io_responder dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (mif)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    bit         sb_chk [$];
    logic [7:0] sb_exp [$];
    string      sb_tag [$];
    logic [7:0] ram_m [int];
    logic [7:0] tx_q [$];
    logic [7:0] rx_q [$];
    int         drops = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_op(input logic [31:0] a, input logic [7:0] d, input logic wr,
                          input bit chk, input logic [7:0] exp, input string tag);
        bit         c;
        logic [7:0] e;
        string      t;
        mif.mem_a    = a;
        mif.mem_dout = d;
        mif.mem_wr   = wr;
        sb_chk.push_back(chk);
        sb_exp.push_back(exp);
        sb_tag.push_back(tag);
        @(posedge clk_in);
        #1;
        c = sb_chk.pop_front();
        e = sb_exp.pop_front();
        t = sb_tag.pop_front();
        if (c) check(t, {24'h0, mif.mem_din}, {24'h0, e});
    endtask

    task automatic idle();
        bus_op(32'h0, 8'h00, 1'b0, 1'b0, 8'h00, "idle");
    endtask

    task automatic ram_write(input logic [31:0] a, input logic [7:0] d);
        ram_m[int'(a & 32'h1FFFF)] = d;
        bus_op(a, d, 1'b1, 1'b0, 8'h00, "ram_wr");
    endtask

    task automatic ram_read(input logic [31:0] a, input string tag);
        bus_op(a, 8'h00, 1'b0, 1'b1, ram_m[int'(a & 32'h1FFFF)], tag);
    endtask

    task automatic io_write(input logic [7:0] d);
        if (mif.tx_ready_in && tx_q.size() != 0)
            check("tx_head_on_write", {24'h0, mif.tx_data_out}, {24'h0, tx_q.pop_front()});
        if (tx_q.size() < 8) tx_q.push_back(d);
        else                 drops++;
        bus_op(32'h0003_0000, d, 1'b1, 1'b0, 8'h00, "io_wr");
        check("io_buffer_full", {31'h0, mif.io_buffer_full}, {31'h0, tx_q.size() >= 7});
    endtask

    task automatic stat_read(input string tag);
        logic [7:0] exp;
        exp = 8'h00;
        exp[1] = (tx_q.size() == 8);
        exp[0] = (rx_q.size() != 0);
        bus_op(32'h0003_0004, 8'h00, 1'b0, 1'b1, exp, tag);
    endtask

    task automatic drop_read(input string tag);
        logic [15:0] exp;
`ifdef MEM_IO_DROP_CNT_EN
        exp = 16'(drops);
`else
        exp = 16'h0;
`endif
        bus_op(32'h0003_0008, 8'h00, 1'b0, 1'b1, exp[7:0],  {tag, "_lo"});
        bus_op(32'h0003_0009, 8'h00, 1'b0, 1'b1, exp[15:8], {tag, "_hi"});
    endtask

    task automatic drain_tx(input int exp_n, input string tag);
        int n;
        n = 0;
        mif.tx_ready_in = 1'b1;
        for (int i = 0; i < 20 && mif.tx_valid_out; i++) begin
            if (tx_q.size() == 0) check({tag, "_extra"}, {31'h0, mif.tx_valid_out}, 32'h0);
            else check({tag, "_byte"}, {24'h0, mif.tx_data_out}, {24'h0, tx_q.pop_front()});
            n++;
            idle();
            check({tag, "_buf_full"}, {31'h0, mif.io_buffer_full}, {31'h0, tx_q.size() >= 7});
        end
        mif.tx_ready_in = 1'b0;
        check({tag, "_count"}, n, exp_n);
        check({tag, "_empty"}, {31'h0, mif.tx_valid_out}, 32'h0);
    endtask

    task automatic rx_push(input logic [7:0] d);
        check("rx_ready", {31'h0, mif.rx_ready_out}, {31'h0, rx_q.size() < 8});
        if (rx_q.size() < 8) rx_q.push_back(d);
        mif.rx_valid_in = 1'b1;
        mif.rx_data_in  = d;
        idle();
        mif.rx_valid_in = 1'b0;
    endtask

    task automatic rx_read(input string tag);
        logic [7:0] exp;
        exp = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
        idle();
        bus_op(32'h0003_0000, 8'h00, 1'b0, 1'b1, exp, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_in          = 1'b1;
        mif.mem_a       = 32'h0;
        mif.mem_dout    = 8'h00;
        mif.mem_wr      = 1'b0;
        mif.tx_ready_in = 1'b0;
        mif.rx_data_in  = 8'h00;
        mif.rx_valid_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_mem_din",   {24'h0, mif.mem_din},        32'h0);
        check("rst_buf_full",  {31'h0, mif.io_buffer_full}, 32'h0);
        check("rst_tx_valid",  {31'h0, mif.tx_valid_out},   32'h0);
        check("rst_rx_ready",  {31'h0, mif.rx_ready_out},   32'h0);
        rst_in = 1'b0;
        #1;
        check("post_rst_rx_ready", {31'h0, mif.rx_ready_out}, 32'h1);

        // RAM write, read-after-write, alias above ADDR_WIDTH
        ram_write(32'h0000_0000, 8'h00);
        ram_write(32'h0000_0010, 8'hA5);
        ram_read(32'h0000_0010, "ram_raw");
        ram_read(32'h0002_0010, "ram_alias");
        ram_write(32'h0002_0011, 8'h3C);
        ram_read(32'h0000_0011, "ram_alias_wr");

        // TX ordering
        io_write(8'h41);
        io_write(8'h42);
        io_write(8'h43);
        check("tx_valid", {31'h0, mif.tx_valid_out}, 32'h1);
        check("tx_head",  {24'h0, mif.tx_data_out},  32'h41);
        drain_tx(3, "tx_order");

        // TX fill: near-full at 7, 8th accepted, 9th dropped
        for (int i = 0; i < 9; i++) io_write(8'h60 + 8'(i));
        stat_read("stat_tx_full");
        drop_read("drop_one");
        drain_tx(8, "tx_fill");

        // Full FIFO with simultaneous push and pop is not a drop
        for (int i = 0; i < 8; i++) io_write(8'h70 + 8'(i));
        mif.tx_ready_in = 1'b1;
        io_write(8'h55);
        mif.tx_ready_in = 1'b0;
        stat_read("stat_full_pushpop");
        drop_read("drop_unchanged");
        drain_tx(8, "tx_pushpop");

        // RX: held read pops once
        rx_push(8'h11);
        rx_push(8'h22);
        stat_read("stat_rx");
        idle();
        bus_op(32'h0003_0000, 8'h00, 1'b0, 1'b1, rx_q.pop_front(), "rx_held_first");
        repeat (3) bus_op(32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h00, "rx_held");
        stat_read("stat_rx_one_pop");
        rx_read("rx_second");
        rx_read("rx_empty");

        // RX full: ready drops and extra valid is ignored
        for (int i = 0; i < 8; i++) rx_push(8'h80 + 8'(i));
        rx_push(8'h99);
        for (int i = 0; i < 9; i++) rx_read("rx_full_drain");

        // Reset mid-operation
        for (int i = 0; i < 7; i++) io_write(8'hB0 + 8'(i));
        rx_push(8'hC1);
        rst_in = 1'b1;
        bus_op(32'h0000_0010, 8'h00, 1'b0, 1'b1, 8'h00, "rst_cycle_read");
        check("midrst_tx_valid", {31'h0, mif.tx_valid_out},   32'h0);
        check("midrst_buf_full", {31'h0, mif.io_buffer_full}, 32'h0);
        check("midrst_rx_ready", {31'h0, mif.rx_ready_out},   32'h0);
        tx_q.delete();
        rx_q.delete();
        drops = 0;
        rst_in = 1'b0;
        #1;
        check("midrst_rx_ready_after", {31'h0, mif.rx_ready_out}, 32'h1);
        ram_read(32'h0000_0010, "ram_kept");
        rx_read("rx_cleared");
        drop_read("drop_cleared");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
Responder end of the CPU byte-wide memory bus: answers the controller's mem_a/mem_dout/mem_wr with mem_din and io_buffer_full.
- Contains a byte RAM plus a memory-mapped IO window, a TX byte FIFO toward the UART side and an RX byte FIFO from it.
- Sits between the memory controller and the board/UART wrapper; used both on FPGA and as the simulation memory model.

Parameters:
ADDR_WIDTH, 17, RAM is 2**ADDR_WIDTH bytes; RAM index = mem_a[ADDR_WIDTH-1:0].
IO_BASE, 32'h0003_0000, first IO address; any mem_a >= IO_BASE is IO space.
TX_DEPTH_LOG, 3, TX FIFO depth = 2**TX_DEPTH_LOG.
RX_DEPTH_LOG, 3, RX FIFO depth = 2**RX_DEPTH_LOG.

Ports:
clk_in  input  1  system clock; single clock domain
rst_in  input  1  synchronous, active-high reset
mem_a  input  32  byte address from controller
mem_dout  input  8  write data from controller
mem_wr  input  1  1 = write this cycle, 0 = read
mem_din  output  8  read data; valid exactly one cycle after address presented
io_buffer_full  output  1  TX FIFO nearly full; controller must not issue IO writes
tx_data_out  output  8  TX FIFO head byte
tx_valid_out  output  1  TX FIFO non-empty
tx_ready_in  input  1  sink accepts; pop when tx_valid_out && tx_ready_in
rx_data_in  input  8  incoming byte
rx_valid_in  input  1  push when rx_valid_in && rx_ready_out
rx_ready_out  output  1  RX FIFO not full

Behaviour:
- Reset (rst_in high at clock edge): mem_din=0, io_buffer_full=0, tx_valid_out=0, rx_ready_out=0 during reset and 1 on the first cycle after, both FIFOs empty, pointers=0. RAM contents not cleared. Reset mid-operation discards FIFO contents; a read issued in the reset cycle returns 0.
- Every cycle is a bus transaction; there is no idle encoding.
- RAM write (mem_a < IO_BASE, mem_wr=1): ram[idx] <= mem_dout at the edge. Address bits above ADDR_WIDTH alias.
- RAM read (mem_a < IO_BASE, mem_wr=0): mem_din <= ram[idx] at the edge, so data appears the following cycle. A read one cycle after a write to the same address returns the new byte.
- IO write to IO_BASE+0: push mem_dout into TX FIFO. If TX is full, drop the byte with no state change. IO writes to other offsets are ignored.
- IO read at IO_BASE+0: mem_din <= RX head, or 0 if RX is empty.
  - Pop only on the first read cycle at that address, i.e. when the previous cycle was not a read of IO_BASE+0. The controller parks its address, so a held address must pop once only.
- IO read at IO_BASE+4: mem_din <= {6'b0, tx_full, rx_nonempty}.
- Other IO reads return 0.
- io_buffer_full is registered: 1 when TX occupancy after this cycle's push/pop is >= depth-1.
- Each FIFO allows push and pop in the same cycle. Count is unchanged and the popped byte is the old head. Push into a full FIFO with a simultaneous pop is accepted.
- Pointers wrap modulo depth. Count is TX_DEPTH_LOG+1 / RX_DEPTH_LOG+1 bits.
- tx_data_out/tx_valid_out and rx_ready_out are combinational from FIFO state.

Optional Feature:
MEM_IO_DROP_CNT_EN
- Defined: a 16-bit saturating counter increments on each dropped TX write. Reading IO_BASE+8 returns its low byte and IO_BASE+9 its high byte. The counter clears on reset.
- Undefined: no counter; IO_BASE+8/9 read 0.

Decomposition:
- Package mem_io_pkg holds:
  - IO offsets: IO_DATA_OFS=0, IO_STAT_OFS=4, IO_DROP_OFS=8.
  - Status bit positions: STAT_RX_NONEMPTY=0, STAT_TX_FULL=1.
  - Default IO_BASE.
- One sub-module, mem_io_byte_fifo (parameter DEPTH_LOG; push/pop/data/full/empty/count), instantiated for both TX and RX.

Test Plan:
- Write 0xA5 to 0x00010, read 0x00010 next cycle -> mem_din=0xA5 in the cycle after the read address; read 0x20010 (alias) -> 0xA5.
- Write 0x41,0x42,0x43 to 0x30000 with tx_ready_in=0 -> tx_valid_out=1, tx_data_out=0x41; raise tx_ready_in for 3 cycles -> bytes 0x41,0x42,0x43 in order, then tx_valid_out=0.
- 7 IO writes with tx_ready_in=0 (depth 8) -> io_buffer_full=1 after the 7th. 8th write accepted, 9th dropped. Drain -> exactly 8 bytes out; with MEM_IO_DROP_CNT_EN a read of 0x30008 -> 0x01.
- Push RX 0x11,0x22; read 0x30004 -> 0x01; hold address 0x30000 as a read for 4 cycles -> mem_din=0x11 and only one pop; move to 0x0 then back to 0x30000 -> 0x22; again -> 0x00.
- Simultaneous TX push and pop with the FIFO full -> count stays 8, no drop; RX full -> rx_ready_out=0 and rx_valid_in ignored.
- Assert rst_in with both FIFOs non-empty -> next cycle tx_valid_out=0, io_buffer_full=0, mem_din=0; RAM byte written before reset still reads back.
